// File: rtl/uart_tx_engine_pkg.sv
// Shared constants, state encoding and parity helper for the UART transmit path.
package uart_tx_engine_pkg;

    localparam int unsigned UART_DATA_WIDTH  = 8;
    localparam int unsigned UART_PARITY_NONE = 0;
    localparam int unsigned UART_PARITY_ODD  = 1;
    localparam int unsigned UART_PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        UART_TX_IDLE,
        UART_TX_START,
        UART_TX_DATA,
        UART_TX_PARITY,
        UART_TX_STOP
    } tx_state_e;

    // Parity over the low `width` bits; ODD inverts the plain XOR.
    function automatic logic parity_bit(input logic [8:0] data,
                                        input int unsigned width,
                                        input int unsigned mode);
        logic [8:0] mask;
        logic       x;
        mask = 9'((10'd1 << width) - 10'd1);
        x    = ^(data & mask);
        return (mode == UART_PARITY_ODD) ? ~x : x;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Byte request handshake between the register slave (master) and the TX engine (slave).
interface uart_tx_engine_if
    import uart_tx_engine_pkg::*;
#(
    parameter int unsigned P_DATA_WIDTH = UART_DATA_WIDTH
);
    logic                    valid;
    logic [P_DATA_WIDTH-1:0] data;
    logic                    ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: one-cycle registered pulse every P_DIV cycles after a clear.
module uart_baud_gen #(
    parameter int unsigned P_DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);
    localparam int unsigned   CW   = (P_DIV > 1) ? $clog2(P_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(P_DIV - 1);
    localparam logic [CW-1:0] PRE  = CW'(P_DIV - 2);

    logic [CW-1:0] cnt;

    // Tick is registered one cycle ahead so it lines up with the counter wrap.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            cnt    <= '0;
            o_tick <= 1'b0;
        end else begin
            cnt    <= (cnt == LAST) ? '0 : cnt + CW'(1);
            o_tick <= (cnt == PRE);
        end
    end
endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: accepts one byte per armed valid and serialises start/data/parity/stop.
module uart_tx_engine
    import uart_tx_engine_pkg::*;
#(
    parameter int unsigned P_CLK_FREQ   = 50_000_000,
    parameter int unsigned P_BAUD_RATE  = 115_200,
    parameter int unsigned P_DATA_WIDTH = UART_DATA_WIDTH,
    parameter int unsigned P_PARITY     = UART_PARITY_NONE,
    parameter int unsigned P_STOP_BITS  = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    uart_tx_engine_if.slave user,
    output logic            o_uart_tx,
    output logic            o_tx_done
);
    localparam int unsigned   DIV       = P_CLK_FREQ / P_BAUD_RATE;
    localparam int unsigned   BW        = $clog2(P_DATA_WIDTH + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(P_DATA_WIDTH - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(P_STOP_BITS - 1);

    tx_state_e               state;
    logic                    armed;
    logic                    tick;
    logic                    accept;
    logic                    parity;
    logic                    frame_end;
    logic [P_DATA_WIDTH-1:0] shreg;
    logic [BW-1:0]           bit_idx;

    // State guard keeps the stale registered ready from re-accepting mid-frame.
    assign accept = user.valid && user.ready && (state == UART_TX_IDLE);

    uart_baud_gen #(.P_DIV(DIV)) u_baud (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (accept),
        .o_tick  (tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= UART_TX_IDLE;
            armed      <= 1'b0;
            shreg      <= '0;
            bit_idx    <= '0;
            parity     <= 1'b0;
            frame_end  <= 1'b0;
            o_uart_tx  <= 1'b1;
            o_tx_done  <= 1'b0;
            user.ready <= 1'b0;
        end else begin
            frame_end <= 1'b0;
            if (!user.valid) begin
                armed <= 1'b1;
            end else if (accept) begin
                armed <= 1'b0;
            end

            case (state)
                UART_TX_IDLE: if (accept) begin
                    shreg   <= user.data;
                    parity  <= parity_bit(9'(user.data), P_DATA_WIDTH, P_PARITY);
                    bit_idx <= '0;
                    state   <= UART_TX_START;
                end
                UART_TX_START: if (tick) state <= UART_TX_DATA;
                UART_TX_DATA: if (tick) begin
                    shreg <= shreg >> 1;
                    if (bit_idx == LAST_DATA) begin
                        bit_idx <= '0;
                        state   <= (P_PARITY != UART_PARITY_NONE) ? UART_TX_PARITY : UART_TX_STOP;
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                UART_TX_PARITY: if (tick) state <= UART_TX_STOP;
                UART_TX_STOP: if (tick) begin
                    if (bit_idx == LAST_STOP) begin
                        bit_idx   <= '0;
                        state     <= UART_TX_IDLE;
                        frame_end <= 1'b1;
                    end else begin
                        bit_idx <= bit_idx + BW'(1);
                    end
                end
                default: state <= UART_TX_IDLE;
            endcase

            // Outputs follow the state register by one edge.
            o_tx_done  <= frame_end;
            user.ready <= (state == UART_TX_IDLE) && armed;
            case (state)
                UART_TX_START:  o_uart_tx <= 1'b0;
                UART_TX_DATA:   o_uart_tx <= shreg[0];
                UART_TX_PARITY: o_uart_tx <= parity;
                default:        o_uart_tx <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench: accepted bytes are queued, line monitors decode frames against a bit-sequence model.
module tb_uart_tx_engine;
    import uart_tx_engine_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned DIV = 8;
    localparam int          F0  = DIV * (1 + W + 0 + 1);
    localparam int          F1  = DIV * (1 + W + 1 + 2);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst0, rst1;
    logic         vld0, vld1;
    logic [W-1:0] dv0, dv1;
    logic         line0, line1, line2, done0, done1, done2;

    int ntests = 0;
    int nfail  = 0;
    int nfr0 = 0, nfr1 = 0, nfr2 = 0;
    int nd0 = 0, nd1 = 0, nd2 = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic [W-1:0] q2[$];

    uart_tx_engine_if #(.P_DATA_WIDTH(W)) u0 ();
    uart_tx_engine_if #(.P_DATA_WIDTH(W)) u1 ();
    uart_tx_engine_if #(.P_DATA_WIDTH(W)) u2 ();

    assign u0.valid = vld0;
    assign u0.data  = dv0;
    assign u1.valid = vld1;
    assign u1.data  = dv1;
    assign u2.valid = vld1;
    assign u2.data  = dv1;

    uart_tx_engine #(.P_CLK_FREQ(800), .P_BAUD_RATE(100), .P_DATA_WIDTH(W),
                     .P_PARITY(UART_PARITY_NONE), .P_STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst(rst0), .user(u0), .o_uart_tx(line0), .o_tx_done(done0));
    uart_tx_engine #(.P_CLK_FREQ(800), .P_BAUD_RATE(100), .P_DATA_WIDTH(W),
                     .P_PARITY(UART_PARITY_EVEN), .P_STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst(rst1), .user(u1), .o_uart_tx(line1), .o_tx_done(done1));
    uart_tx_engine #(.P_CLK_FREQ(800), .P_BAUD_RATE(100), .P_DATA_WIDTH(W),
                     .P_PARITY(UART_PARITY_ODD), .P_STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_rst(rst1), .user(u2), .o_uart_tx(line2), .o_tx_done(done2));

    always @(negedge clk) begin
        if (done0 === 1'b1) nd0 <= nd0 + 1;
        if (done1 === 1'b1) nd1 <= nd1 + 1;
        if (done2 === 1'b1) nd2 <= nd2 + 1;
    end

    function automatic logic line_of(input int ch);
        case (ch)
            0:       return line0;
            1:       return line1;
            default: return line2;
        endcase
    endfunction

    function automatic logic done_of(input int ch);
        case (ch)
            0:       return done0;
            1:       return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic rst_of(input int ch);
        return (ch == 0) ? rst0 : rst1;
    endfunction

    function automatic logic ready_of(input int k);
        return (k == 0) ? u0.ready : u1.ready;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Decodes every frame on one line and compares it with the next queued byte.
    task automatic monitor(input int ch, input int par, input int stops);
        logic         prev;
        logic         have;
        logic         ok;
        logic         aborted;
        logic [W-1:0] exp;
        logic [15:0]  bits;
        int           nb;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_of(ch) && prev && !line_of(ch)) begin
                have = 1'b0;
                exp  = '0;
                if (ch == 0 && q0.size() > 0) begin exp = q0.pop_front(); have = 1'b1; end
                if (ch == 1 && q1.size() > 0) begin exp = q1.pop_front(); have = 1'b1; end
                if (ch == 2 && q2.size() > 0) begin exp = q2.pop_front(); have = 1'b1; end
                if (!have) check_bit($sformatf("ch%0d_unexpected_frame", ch), 1'b1, 1'b0);
                bits       = '1;
                bits[0]    = 1'b0;
                bits[W:1]  = exp;
                if (par != 0) bits[W+1] = (^exp) ^ (par == 1);
                nb      = 1 + W + ((par != 0) ? 1 : 0) + stops;
                aborted = 1'b0;
                for (int b = 0; b < nb && !aborted; b++) begin
                    ok = 1'b1;
                    for (int s = 0; s < DIV && !aborted; s++) begin
                        if (!(b == 0 && s == 0)) @(negedge clk);
                        if (rst_of(ch)) aborted = 1'b1;
                        else if (line_of(ch) !== bits[0] || done_of(ch) !== 1'b0) ok = 1'b0;
                    end
                    if (!aborted && have)
                        check_bit($sformatf("ch%0d_bit%0d_of_%02h", ch, b, exp), ok, 1'b1);
                    bits = bits >> 1;
                end
                if (!aborted) begin
                    @(negedge clk);
                    if (have) begin
                        check_bit($sformatf("ch%0d_done_pulse", ch), done_of(ch), 1'b1);
                        check_bit($sformatf("ch%0d_idle_after_frame", ch), line_of(ch), 1'b1);
                    end
                    if (ch == 0) nfr0++; else if (ch == 1) nfr1++; else nfr2++;
                end
            end
            prev = line_of(ch);
        end
    endtask

    task automatic set_valid(input int k, input logic v, input logic [W-1:0] d);
        if (k == 0) begin vld0 = v; dv0 = d; end
        else        begin vld1 = v; dv1 = d; end
    endtask

    // Raises valid, waits for ready, records the byte; returns one negedge after the accept edge.
    task automatic accept_only(input int k, input logic [W-1:0] dat);
        int n;
        n = 0;
        set_valid(k, 1'b1, dat);
        while (!ready_of(k) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_bit("accept_ready", ready_of(k), 1'b1);
        if (k == 0) q0.push_back(dat);
        else begin q1.push_back(dat); q2.push_back(dat); end
        @(negedge clk);
    endtask

    task automatic wait_ready(input int k);
        int n;
        n = 0;
        while (!ready_of(k) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_bit("wait_ready", ready_of(k), 1'b1);
    endtask

    initial begin
        fork
            monitor(0, 0, 1);
            monitor(1, 2, 2);
            monitor(2, 1, 2);
        join_none
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", ntests, nfail + 1);
        $fatal(1);
    end

    initial begin
        logic [W-1:0] d;
        int           k;
        vld0 = 1'b0; vld1 = 1'b0; dv0 = '0; dv1 = '0;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("reset_line0", line0, 1'b1);
        check_bit("reset_line1", line1, 1'b1);
        check_bit("reset_line2", line2, 1'b1);
        check_bit("reset_ready0", u0.ready, 1'b0);
        check_bit("reset_ready1", u1.ready, 1'b0);
        check_bit("reset_done0", done0, 1'b0);
        rst0 = 1'b0; rst1 = 1'b0;
        repeat (3) @(negedge clk);
        check_bit("armed_ready0", u0.ready, 1'b1);
        check_bit("armed_ready2", u2.ready, 1'b1);

        // Single 8N1 frame with accept latency
        accept_only(0, 8'hA5);
        check_bit("latency_line_before", line0, 1'b1);
        vld0 = 1'b0;
        @(negedge clk);
        check_bit("latency_start_bit", line0, 1'b0);
        check_bit("latency_ready_fall", u0.ready, 1'b0);
        wait_ready(0);

        // Held valid: one frame only, ready returns one edge after valid sampled low
        accept_only(0, 8'h3E);
        repeat (F0 + 30) @(negedge clk);
        check_bit("held_ready_low", u0.ready, 1'b0);
        vld0 = 1'b0;
        @(negedge clk);
        check_bit("rearm_not_yet", u0.ready, 1'b0);
        @(negedge clk);
        check_bit("rearm_ready", u0.ready, 1'b1);

        // Back-to-back: valid low for exactly one sampled edge
        accept_only(0, 8'h00);
        repeat (F0 - 1) @(negedge clk);
        vld0 = 1'b0;
        @(negedge clk);
        vld0 = 1'b1;
        dv0  = 8'hFF;
        @(negedge clk);
        check_bit("b2b_done", done0, 1'b1);
        check_bit("b2b_ready", u0.ready, 1'b1);
        q0.push_back(8'hFF);
        @(negedge clk);
        vld0 = 1'b0;
        check_bit("b2b_gap_high", line0, 1'b1);
        @(negedge clk);
        check_bit("b2b_second_start", line0, 1'b0);
        wait_ready(0);

        // Data changes after accept are ignored
        accept_only(0, 8'h3C);
        dv0 = 8'hC3;
        repeat (2) @(negedge clk);
        vld0 = 1'b0;
        wait_ready(0);

        // Reset during data bit 3
        accept_only(0, 8'h96);
        vld0 = 1'b0;
        repeat (DIV * 4 + 3) @(negedge clk);
        rst0 = 1'b1;
        @(negedge clk);
        check_bit("midrst_line", line0, 1'b1);
        check_bit("midrst_ready", u0.ready, 1'b0);
        @(negedge clk);
        rst0 = 1'b0;
        wait_ready(0);
        accept_only(0, 8'h5A);
        vld0 = 1'b0;
        wait_ready(0);

        // Parity / two stop bits: EVEN and ODD engines share the stimulus
        accept_only(1, 8'h07);
        vld1 = 1'b0;
        @(negedge clk);
        check_bit("par_start_even", line1, 1'b0);
        check_bit("par_start_odd", line2, 1'b0);
        wait_ready(1);

        // Randomized traffic with optional data glitch and extra hold
        for (int i = 0; i < 10; i++) begin
            d = W'($urandom());
            k = int'($urandom_range(0, 1));
            accept_only(k, d);
            if ($urandom_range(0, 1) == 1) set_valid(k, 1'b1, ~d);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            set_valid(k, 1'b0, d);
            wait_ready(k);
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check_int("q0_drained", q0.size(), 0);
        check_int("q1_drained", q1.size(), 0);
        check_int("q2_drained", q2.size(), 0);
        check_int("done_count0", nd0, nfr0);
        check_int("done_count1", nd1, nfr1);
        check_int("done_count2", nd2, nfr2);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
